lsu_handshake: RTL

- Load/store unit sitting between the multi-cycle MIPS core's EX stage and a data-memory port with valid/ready handshakes and variable latency, replacing the fixed one-cycle SRAM access.
- Performs byte-lane steering, write-strobe generation, load extension, LWL/LWR merge, SWL/SWR lane shifting and alignment-exception detection.
- Parametrised over memory data width; adds back-pressure and multi-cycle waits.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane.sv | 121 ++++++++++++
 rtl/lsu_handshake.sv | 109 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: operation encoding,
// handshake FSM states and exception codes.
package lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd7,
    SH  = 4'd8,
    SW  = 4'd9,
    SWL = 4'd10,
    SWR = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  function automatic logic is_load(lsu_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction

  function automatic logic is_store(lsu_op_t op);
    return op inside {SB, SH, SW, SWL, SWR};
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: store strobes/data, load extension and
// LWL/LWR merge, plus alignment check. 64-bit buses select a word by off[2].
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  lsu_op_t                          op,
  input  logic [$clog2(DATA_W/8)-1:0]      off,
  input  logic [31:0]                      rt,
  input  logic [DATA_W-1:0]                rdata,
  output logic [DATA_W/8-1:0]              wstrb_c,
  output logic [DATA_W-1:0]                wdata_c,
  output logic [31:0]                      rdata_c,
  output logic                             misaligned_c
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  logic [1:0]  a;
  logic [3:0]  strb4;
  logic [31:0] wd32;
  logic [31:0] m;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign a = off[1:0];

  // Word-lane placement for wide buses
  generate
    if (DATA_W == 64) begin : g_w64
      logic hi;
      assign hi      = off[OFF_W-1];
      assign m       = hi ? rdata[DATA_W-1:32] : rdata[31:0];
      assign wstrb_c = hi ? {strb4, 4'h0} : {4'h0, strb4};
      assign wdata_c = hi ? {wd32, 32'h0} : {32'h0, wd32};
    end else begin : g_w32
      assign m       = rdata;
      assign wstrb_c = strb4;
      assign wdata_c = wd32;
    end
  endgenerate

  always_comb begin
    strb4 = 4'h0;
    wd32  = 32'h0;
    unique case (op)
      SB: begin
        strb4 = 4'b0001 << a;
        wd32  = {4{rt[7:0]}};
      end
      SH: begin
        strb4 = a[1] ? 4'b1100 : 4'b0011;
        wd32  = {2{rt[15:0]}};
      end
      SW: begin
        strb4 = 4'b1111;
        wd32  = rt;
      end
      SWL: begin
        unique case (a)
          2'd0:    begin strb4 = 4'b0001; wd32 = {24'h0, rt[31:24]}; end
          2'd1:    begin strb4 = 4'b0011; wd32 = {16'h0, rt[31:16]}; end
          2'd2:    begin strb4 = 4'b0111; wd32 = {8'h0, rt[31:8]};   end
          default: begin strb4 = 4'b1111; wd32 = rt;                 end
        endcase
      end
      SWR: begin
        unique case (a)
          2'd0:    begin strb4 = 4'b1111; wd32 = rt;                 end
          2'd1:    begin strb4 = 4'b1110; wd32 = {rt[23:0], 8'h0};   end
          2'd2:    begin strb4 = 4'b1100; wd32 = {rt[15:0], 16'h0};  end
          default: begin strb4 = 4'b1000; wd32 = {rt[7:0], 24'h0};   end
        endcase
      end
      default: ;
    endcase
  end

  assign byte_v = 8'(m >> {a, 3'b000});
  assign half_v = a[1] ? m[31:16] : m[15:0];

  always_comb begin
    rdata_c = 32'h0;
    unique case (op)
      LB:  rdata_c = {{24{byte_v[7]}}, byte_v};
      LBU: rdata_c = {24'h0, byte_v};
      LH:  rdata_c = {{16{half_v[15]}}, half_v};
      LHU: rdata_c = {16'h0, half_v};
      LW:  rdata_c = m;
      LWL: begin
        unique case (a)
          2'd0:    rdata_c = {m[7:0], rt[23:0]};
          2'd1:    rdata_c = {m[15:0], rt[15:0]};
          2'd2:    rdata_c = {m[23:0], rt[7:0]};
          default: rdata_c = m;
        endcase
      end
      LWR: begin
        unique case (a)
          2'd0:    rdata_c = m;
          2'd1:    rdata_c = {rt[31:24], m[31:8]};
          2'd2:    rdata_c = {rt[31:16], m[31:16]};
          default: rdata_c = {rt[31:8], m[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    misaligned_c = 1'b0;
    unique case (op)
      LH, LHU, SH: misaligned_c = a[0];
      LW, SW:      misaligned_c = |a;
      default:     misaligned_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_handshake.sv
// Load/store unit between EX and a valid/ready data-memory port with
// variable latency; one access in flight, registered outputs throughout.
module lsu_handshake
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  lsu_op_t               req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_exc,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  lsu_state_t         state_q, state_d;
  lsu_op_t            op_q, lane_op;
  logic [OFF_W-1:0]   off_q, lane_off;
  logic [31:0]        rt_q, lane_rt;
  logic               accept;
  logic [STRB_W-1:0]  wstrb_c;
  logic [DATA_W-1:0]  wdata_c;
  logic [31:0]        ld_c;
  logic               misaligned_c;

  // Steering sees the live request while idle, the latched one afterwards
  assign lane_op  = (state_q == S_IDLE) ? req_op : op_q;
  assign lane_off = (state_q == S_IDLE) ? req_addr[OFF_W-1:0] : off_q;
  assign lane_rt  = (state_q == S_IDLE) ? req_wdata : rt_q;

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .op           (lane_op),
    .off          (lane_off),
    .rt           (lane_rt),
    .rdata        (mem_rdata),
    .wstrb_c      (wstrb_c),
    .wdata_c      (wdata_c),
    .rdata_c      (ld_c),
    .misaligned_c (misaligned_c)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = misaligned_c ? S_RESP : S_REQ;
      end
      S_REQ:  if (mem_addr_ok) state_d = mem_data_ok ? S_RESP : S_WAIT;
      S_WAIT: if (mem_data_ok) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      op_q       <= LB;
      off_q      <= '0;
      rt_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == S_IDLE);
      mem_req    <= (state_d == S_REQ);
      resp_valid <= (state_d == S_RESP);
      resp_exc   <= (state_q == S_IDLE) && (state_d == S_RESP);
      if (accept) begin
        op_q       <= req_op;
        off_q      <= req_addr[OFF_W-1:0];
        rt_q       <= req_wdata;
        resp_rdata <= '0;
        mem_wr     <= is_store(req_op);
        mem_addr   <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        mem_wstrb  <= wstrb_c;
        mem_wdata  <= wdata_c;
      end
      // Load data is captured on the cycle the memory completes
      if ((state_q != S_IDLE) && (state_d == S_RESP)) resp_rdata <= ld_c;
    end
  end

endmodule
